// File: rtl/pc_pkg.sv
// Shared op encodings for the program-counter unit.
// Imported by the PC datapath and its testbench.
package pc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC    = 3'd0;
  localparam logic [OP_W-1:0] OP_HOLD   = 3'd1;
  localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'd3;
  localparam logic [OP_W-1:0] OP_CALL   = 3'd4;
  localparam logic [OP_W-1:0] OP_RET    = 3'd5;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO storage plus level counter.
// Push on full and pop on empty are ignored.
module ras_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] top;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top     = level - LW'(1);
  assign dout    = empty ? '0 : mem[IW'(top)];

  // Storage is written at the current level; it is never cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[IW'(level)] <= din;
  end

  // Level counter tracks the number of valid entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (do_push) begin
      level <= level + LW'(1);
    end else if (do_pop) begin
      level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with stall, jump, relative branch and
// call/return through a hardware return-address stack.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [OP_W-1:0]                op,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_level,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ovf_err,
  output logic                           unf_err
);

  logic [ADDR_W-1:0] addend;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              ovf_nx;
  logic              unf_nx;

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sum),
    .dout  (ret_addr),
    .level (ras_level),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // One adder serves INC, BRANCH and the CALL return address.
  always_comb begin
    addend = (op == OP_BRANCH) ? target : ADDR_W'(1);
    sum    = pc + addend;
  end

  // Next-PC mux and stack/error control.
  always_comb begin
    pc_nx  = pc;
    push   = 1'b0;
    pop    = 1'b0;
    ovf_nx = 1'b0;
    unf_nx = 1'b0;
    case (op)
      OP_INC:    pc_nx = sum;
      OP_JUMP:   pc_nx = target;
      OP_BRANCH: pc_nx = sum;
      OP_CALL: begin
        if (!ras_full) begin
          push  = 1'b1;
          pc_nx = target;
        end else begin
          ovf_nx = 1'b1;
        end
      end
      OP_RET: begin
        if (!ras_empty) begin
          pop   = 1'b1;
          pc_nx = ret_addr;
        end else begin
          unf_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // PC and error-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_ADDR;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      pc      <= pc_nx;
      ovf_err <= ovf_nx;
      unf_err <= unf_nx;
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit with directed vectors.
// Stimulus queues expectations; a monitor pops and checks.
module tb_pc_ras_unit;
  import pc_pkg::*;

  typedef struct {
    string      nm;
    logic [7:0] pc;
    logic [2:0] lv;
    logic       o;
    logic       u;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic [7:0] target;
  logic [7:0] pc;
  logic [2:0] ras_level;
  logic       ras_full;
  logic       ras_empty;
  logic       ovf_err;
  logic       unf_err;
  logic       chk = 1'b0;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_ras_unit #(
    .ADDR_W     (8),
    .RAS_DEPTH  (4),
    .RESET_ADDR (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .target    (target),
    .pc        (pc),
    .ras_level (ras_level),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  always #5 clk = ~clk;

  // Monitor: check the oldest expectation away from the active edge.
  always @(negedge clk or posedge chk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic ef, ee;
      e  = q.pop_front();
      ef = (e.lv == 3'd4);
      ee = (e.lv == 3'd0);
      n_cmp++;
      if (pc !== e.pc || ras_level !== e.lv || ras_full !== ef ||
          ras_empty !== ee || ovf_err !== e.o || unf_err !== e.u) begin
        n_bad++;
        $display("FAIL %s: got pc=%h lv=%0d f=%b e=%b o=%b u=%b, want pc=%h lv=%0d f=%b e=%b o=%b u=%b",
                 e.nm, pc, ras_level, ras_full, ras_empty, ovf_err, unf_err,
                 e.pc, e.lv, ef, ee, e.o, e.u);
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic [7:0] p,
                              input logic [2:0] l, input logic o,
                              input logic u);
    exp_t e;
    e.nm = nm; e.pc = p; e.lv = l; e.o = o; e.u = u;
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [7:0] t,
                       input string nm, input logic [7:0] p,
                       input logic [2:0] l, input logic eo = 1'b0,
                       input logic eu = 1'b0);
    op = o;
    target = t;
    @(posedge clk);
    #1;
    q.push_back(mk(nm, p, l, eo, eu));
  endtask

  task automatic check_now(input string nm, input logic [7:0] p,
                           input logic [2:0] l);
    q.push_back(mk(nm, p, l, 1'b0, 1'b0));
    chk = 1'b1;
    #1;
    chk = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    op = OP_HOLD;
    target = '0;
    #3;
    check_now("reset", 8'h00, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(OP_INC, 8'h00, "inc1", 8'h01, 3'd0);
    issue(OP_INC, 8'h00, "inc2", 8'h02, 3'd0);
    issue(OP_INC, 8'h00, "inc3", 8'h03, 3'd0);
    issue(OP_INC, 8'h00, "inc4", 8'h04, 3'd0);
    issue(OP_CALL, 8'h05, "call_pre", 8'h05, 3'd1);
    #6;
    reset = 1'b1;
    #1;
    check_now("async_reset", 8'h00, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(OP_JUMP, 8'hFE, "jmp_fe", 8'hFE, 3'd0);
    issue(OP_INC, 8'h00, "inc_ff", 8'hFF, 3'd0);
    issue(OP_INC, 8'h00, "inc_wrap", 8'h00, 3'd0);
    issue(OP_JUMP, 8'h10, "jmp_10", 8'h10, 3'd0);
    issue(OP_BRANCH, 8'hF0, "br_back", 8'h00, 3'd0);
    issue(OP_BRANCH, 8'h05, "br_fwd", 8'h05, 3'd0);
    issue(OP_JUMP, 8'hF0, "jmp_f0", 8'hF0, 3'd0);
    issue(OP_BRANCH, 8'h20, "br_wrap", 8'h10, 3'd0);

    issue(OP_JUMP, 8'h20, "jmp_20", 8'h20, 3'd0);
    issue(OP_CALL, 8'h80, "call_80", 8'h80, 3'd1);
    issue(OP_INC, 8'h00, "inc_81", 8'h81, 3'd1);
    issue(OP_RET, 8'h00, "ret_21", 8'h21, 3'd0);

    issue(OP_JUMP, 8'h00, "jmp_00", 8'h00, 3'd0);
    issue(OP_CALL, 8'h10, "call_10", 8'h10, 3'd1);
    issue(OP_CALL, 8'h20, "call_20", 8'h20, 3'd2);
    issue(OP_CALL, 8'h30, "call_30", 8'h30, 3'd3);
    issue(OP_CALL, 8'h40, "call_40", 8'h40, 3'd4);
    issue(OP_CALL, 8'h50, "call_ovf", 8'h40, 3'd4, 1'b1, 1'b0);
    issue(OP_CALL, 8'h60, "call_ovf2", 8'h40, 3'd4, 1'b1, 1'b0);
    issue(OP_HOLD, 8'h00, "ovf_clr", 8'h40, 3'd4);
    issue(OP_RET, 8'h00, "ret_31", 8'h31, 3'd3);
    issue(OP_RET, 8'h00, "ret_21b", 8'h21, 3'd2);
    issue(OP_RET, 8'h00, "ret_11", 8'h11, 3'd1);
    issue(OP_RET, 8'h00, "ret_01", 8'h01, 3'd0);

    issue(OP_JUMP, 8'h07, "jmp_07", 8'h07, 3'd0);
    issue(OP_RET, 8'h00, "unf1", 8'h07, 3'd0, 1'b0, 1'b1);
    issue(OP_HOLD, 8'h00, "unf_clr", 8'h07, 3'd0);
    issue(OP_RET, 8'h00, "unf2a", 8'h07, 3'd0, 1'b0, 1'b1);
    issue(OP_RET, 8'h00, "unf2b", 8'h07, 3'd0, 1'b0, 1'b1);
    issue(OP_HOLD, 8'h00, "unf_clr2", 8'h07, 3'd0);

    issue(OP_JUMP, 8'h40, "jmp_40", 8'h40, 3'd0);
    issue(OP_CALL, 8'h33, "call_33", 8'h33, 3'd1);
    issue(OP_HOLD, 8'h99, "hold", 8'h33, 3'd1);
    issue(3'd6, 8'h99, "rsv6", 8'h33, 3'd1);
    issue(3'd7, 8'h99, "rsv7", 8'h33, 3'd1);
    issue(OP_RET, 8'h00, "ret_41", 8'h41, 3'd0);

    issue(OP_JUMP, 8'hFF, "jmp_ff", 8'hFF, 3'd0);
    issue(OP_CALL, 8'h10, "call_wrap", 8'h10, 3'd1);
    issue(OP_RET, 8'h00, "ret_wrap", 8'h00, 3'd0);
    op = OP_HOLD;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program-counter unit for the teaching CPU datapath. It supersedes the fixed 8-bit jump-capable counter and adds an enable/stall, PC-relative branches, and subroutine call/return backed by a hardware return-address stack (RAS). It sits between the control unit, which issues one op per cycle, and the instruction-memory address port.

## Interface
- ADDR_W, 8, PC and address width in bits (≥2)
- RAS_DEPTH, 4, return-address stack entries (≥1)
- RESET_ADDR, 0, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  3  operation code, encodings in pc_pkg
- target  in  ADDR_W  absolute address (JUMP, CALL) or two's-complement offset (BRANCH)
- pc  out  ADDR_W  current program counter, registered
- ras_level  out  $clog2(RAS_DEPTH+1)  number of valid stack entries
- ras_full  out  1  ras_level == RAS_DEPTH
- ras_empty  out  1  ras_level == 0
- ovf_err  out  1  one-cycle pulse: CALL attempted while full
- unf_err  out  1  one-cycle pulse: RET attempted while empty

## Operation
- Ops are sampled on every rising clk edge; all results are registered.
- OP_INC (0): pc ← pc+1.
- OP_HOLD (1): pc unchanged (stall).
- OP_JUMP (2): pc ← target.
- OP_BRANCH (3): pc ← pc + target, with target signed.
- OP_CALL (4): push pc+1, then pc ← target, ras_level+1.
- OP_RET (5): pc ← top of stack, pop, ras_level−1.
- Codes 6 and 7 are reserved and behave as OP_HOLD, with no error flag.
- All PC arithmetic is modulo 2^ADDR_W:
  - INC from all-ones gives 0.
  - BRANCH wraps in both directions.
  - The pushed return address from all-ones is 0.
- CALL when ras_full:
  - pc and stack unchanged.
  - ovf_err=1 for the next cycle.
- RET when ras_empty:
  - pc unchanged.
  - unf_err=1 for the next cycle.
- The stack is strictly LIFO. Entries at or above ras_level are don't-care and are never observable on pc.
- Error pulses last exactly one cycle per offending op. Back-to-back offending ops give a continuous high level.
- Reset (asynchronous, any time, including mid-sequence):
  - pc=RESET_ADDR, ras_level=0, ras_empty=1, ras_full=0, ovf_err=0, unf_err=0.
  - Stack storage is not cleared.

## Timing
- Latency is 1 cycle: op presented before edge N is reflected on pc, ras_level and flags after edge N.
- ras_full and ras_empty are combinational decodes of the registered ras_level, so they have no extra latency.
- There is no handshake. The control unit must hold op stable around the edge; HOLD is the only stall mechanism.
- A CALL and the following RET on consecutive cycles must work: RET returns the address pushed one cycle earlier.
- Reset deassertion is synchronised by the system. The first op is taken on the first edge after deassertion.

## Structure
- Package pc_pkg holds:
  - op width constant OP_W=3.
  - localparams OP_INC, OP_HOLD, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET.
- Sub-module ras_stack(W, DEPTH):
  - Storage array plus level counter.
  - Inputs push, pop, din. Outputs dout (top), level, full, empty.
  - Guards against push-when-full and pop-when-empty internally.
- Top level contains:
  - next-PC mux.
  - adder for INC, BRANCH and return address.
  - error pulse registers.

## Test plan
- Reset then 5× INC (ADDR_W=8, RESET_ADDR=0) → pc 1,2,3,4,5; assert reset mid-stream → pc=0, ras_level=0 immediately, without waiting for a clock edge.
- From pc=0xFE: INC, INC → pc 0xFF, 0x00; at pc=0x10, BRANCH target=0xF0 (−16) → pc 0x00; BRANCH 0x05 → 0x05.
- At pc=0x20: CALL 0x80 → pc 0x80, ras_level 1; INC → 0x81; RET → pc 0x21, ras_level 0, ras_empty 1.
- Nested CALLs from pc 0x00 → 0x10 → 0x20 → 0x30 → 0x40 (DEPTH=4) → ras_full=1; fifth CALL 0x50 → pc stays 0x40, ovf_err pulses 1 cycle; four RETs → pc 0x31, 0x21, 0x11, 0x01.
- RET with empty stack at pc=0x07 → pc stays 0x07, unf_err 1 cycle; two consecutive such RETs → unf_err high 2 cycles.
- HOLD and reserved codes 6, 7 at pc=0x33 → pc stays 0x33, no error flags, ras_level unchanged.
